// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-side and decode-side handshake bundle for id_stage
interface id_stage_if #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [5:0]      opcode;
   logic [5:0]      func;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [4:0]      sa;
   logic [XLEN-1:0] imm_ext;
   logic [25:0]     address;
   logic [1:0]      fmt;
   logic            illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, func, rs, rt, rd, sa,
             imm_ext, address, fmt, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, func, rs, rt, rd, sa,
             imm_ext, address, fmt, illegal
   );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage with 2-entry skid buffer and flush
// Optional extra slt/sltu/nor/slti/sltiu decode enabled by macro ID_EXT_OPS_EN.
module id_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   id_stage_if.slave  io
);

`ifdef ID_EXT_OPS_EN
   localparam bit EXT_OPS = 1'b1;
`else
   localparam bit EXT_OPS = 1'b0;
`endif

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [5:0]      opcode;
      logic [5:0]      func;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [4:0]      sa;
      logic [XLEN-1:0] imm;
      logic [25:0]     addr;
      logic [1:0]      fmt;
      logic            ill;
   } ent_t;

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [15:0] imm16;
   logic        r_ok, i_ok, j_ok, zext, lui;
   ent_t        dec;

   assign op    = io.in_instr[31:26];
   assign fn    = io.in_instr[5:0];
   assign imm16 = io.in_instr[15:0];
   assign j_ok  = (op == 6'b000010) || (op == 6'b000011);

   always_comb begin
      r_ok = 1'b0;
      i_ok = 1'b0;
      zext = 1'b0;
      lui  = 1'b0;
      case (fn)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
         6'b000000, 6'b000010, 6'b000011, 6'b001000: r_ok = (op == 6'b000000);
         6'b101010, 6'b101011, 6'b100111:            r_ok = (op == 6'b000000) && EXT_OPS;
         default: ;
      endcase
      case (op)
         6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000101: i_ok = 1'b1;
         6'b001100, 6'b001101, 6'b001110: begin
            i_ok = 1'b1;
            zext = 1'b1;
         end
         6'b001111: begin
            i_ok = 1'b1;
            lui  = 1'b1;
         end
         6'b001010, 6'b001011: i_ok = EXT_OPS;
         default: ;
      endcase
   end

   // Fields outside the recognised format stay zero; illegal keeps only opcode.
   always_comb begin
      dec        = '0;
      dec.pc     = io.in_pc;
      dec.opcode = op;
      if (r_ok) begin
         dec.rs   = io.in_instr[25:21];
         dec.rt   = io.in_instr[20:16];
         dec.rd   = io.in_instr[15:11];
         dec.sa   = io.in_instr[10:6];
         dec.func = fn;
         dec.fmt  = 2'd0;
      end else if (i_ok) begin
         dec.rs  = io.in_instr[25:21];
         dec.rt  = io.in_instr[20:16];
         dec.fmt = 2'd1;
         if (zext)
            dec.imm = XLEN'(imm16);
         else if (lui)
            dec.imm = XLEN'($signed({imm16, 16'h0000}));
         else
            dec.imm = XLEN'($signed(imm16));
      end else if (j_ok) begin
         dec.addr = io.in_instr[25:0];
         dec.fmt  = 2'd2;
      end else begin
         dec.fmt = 2'd3;
         dec.ill = 1'b1;
      end
   end

   ent_t head, skid, head_n, skid_n;
   logic head_v, skid_v, head_v_n, skid_v_n, rdy;
   logic acc, pop;

   assign acc = io.in_valid && rdy;
   assign pop = head_v && io.out_ready;

   always_comb begin
      head_n   = head;
      skid_n   = skid;
      head_v_n = head_v;
      skid_v_n = skid_v;
      if (flush) begin
         head_v_n = 1'b0;
         skid_v_n = 1'b0;
      end else if (!head_v) begin
         if (acc) begin
            head_n   = dec;
            head_v_n = 1'b1;
         end
      end else if (pop) begin
         if (skid_v) begin
            head_n   = skid;
            skid_v_n = 1'b0;
         end else if (acc) begin
            head_n = dec;
         end else begin
            head_v_n = 1'b0;
         end
      end else if (acc) begin
         skid_n   = dec;
         skid_v_n = 1'b1;
      end
   end

   // rdy resets low so in_ready only rises on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head   <= '0;
         skid   <= '0;
         head_v <= 1'b0;
         skid_v <= 1'b0;
         rdy    <= 1'b0;
      end else begin
         head   <= head_n;
         skid   <= skid_n;
         head_v <= head_v_n;
         skid_v <= skid_v_n;
         rdy    <= !skid_v_n;
      end
   end

   assign io.in_ready  = rdy;
   assign io.out_valid = head_v;
   assign io.out_pc    = head.pc;
   assign io.opcode    = head.opcode;
   assign io.func      = head.func;
   assign io.rs        = head.rs;
   assign io.rt        = head.rt;
   assign io.rd        = head.rd;
   assign io.sa        = head.sa;
   assign io.imm_ext   = head.imm;
   assign io.address   = head.addr;
   assign io.fmt       = head.fmt;
   assign io.illegal   = head.ill;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a queue model
module tb_id_stage;
   localparam int XLEN = 32;
   localparam int PC_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   id_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

   id_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .io    (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit [63:0] pc, opcode, func, rs, rt, rd, sa, imm, addr, fmt, ill;
   } exp_t;

   exp_t q[$];
   bit [5:0] r_funcs[$];
   bit [5:0] i_ops[$];
   bit [5:0] all_ops[$];
   bit [5:0] all_funcs[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit in_list(input bit [5:0] v, input bit [5:0] lst[$]);
      foreach (lst[i]) if (lst[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t ref_decode(input bit [31:0] ins, input bit [31:0] pc);
      exp_t e;
      bit [5:0] op;
      longint s;
      e = '{default: 0};
      op = ins[31:26];
      s = longint'($signed(ins[15:0]));
      e.pc = pc;
      e.opcode = op;
      if (op == 0 && in_list(ins[5:0], r_funcs)) begin
         e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
         e.sa = ins[10:6];  e.func = ins[5:0]; e.fmt = 0;
      end else if (in_list(op, i_ops)) begin
         e.rs = ins[25:21]; e.rt = ins[20:16]; e.fmt = 1;
         if (op == 6'h0c || op == 6'h0d || op == 6'h0e) e.imm = ins[15:0];
         else if (op == 6'h0f) e.imm = s * 65536;
         else e.imm = s;
         if (XLEN == 32) e.imm = e.imm & 64'hFFFF_FFFF;
      end else if (op == 6'h02 || op == 6'h03) begin
         e.addr = ins[25:0]; e.fmt = 2;
      end else begin
         e.fmt = 3; e.ill = 1;
      end
      return e;
   endfunction

   task automatic compare_out();
      exp_t e;
      check("out_valid", bus.out_valid, q.size() > 0);
      check("in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
         e = q[0];
         check("out_pc", bus.out_pc, e.pc);
         check("opcode", bus.opcode, e.opcode);
         check("func", bus.func, e.func);
         check("rs", bus.rs, e.rs);
         check("rt", bus.rt, e.rt);
         check("rd", bus.rd, e.rd);
         check("sa", bus.sa, e.sa);
         check("imm_ext", bus.imm_ext, e.imm);
         check("address", bus.address, e.addr);
         check("fmt", bus.fmt, e.fmt);
         check("illegal", bus.illegal, e.ill);
      end
   endtask

   task automatic step(input bit v, input bit [31:0] ins, input bit ordy, input bit fl);
      bit acc, pop;
      bit [31:0] pc;
      exp_t e;
      pc = $urandom;
      bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
      bus.out_ready = ordy; flush = fl;
      acc = v && (q.size() < 2);
      pop = ordy && (q.size() > 0);
      e = ref_decode(ins, pc);
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (pop) q.delete(0);
         if (acc) q.push_back(e);
      end
      @(negedge clk);
      compare_out();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0; flush = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_opcode", bus.opcode, 0);
      check("rst_imm_ext", bus.imm_ext, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_fmt", bus.fmt, 0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      compare_out();
   endtask

   function automatic bit [31:0] rand_instr();
      bit [31:0] r;
      r = $urandom;
      case ($urandom % 4)
         0: r[31:26] = all_ops[$urandom_range(0, all_ops.size() - 1)];
         1: begin r[31:26] = 6'b0; r[5:0] = all_funcs[$urandom_range(0, all_funcs.size() - 1)]; end
         2: r[31:26] = ($urandom % 2) ? 6'h0f : 6'h0c;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      r_funcs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
      i_ops   = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h0f};
`ifdef ID_EXT_OPS_EN
      r_funcs.push_back(6'h2a); r_funcs.push_back(6'h2b); r_funcs.push_back(6'h27);
      i_ops.push_back(6'h0a);   i_ops.push_back(6'h0b);
`endif
      all_ops   = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h0f,
                    6'h0a, 6'h0b, 6'h02, 6'h03, 6'h01, 6'h3f};
      all_funcs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08,
                    6'h2a, 6'h2b, 6'h27, 6'h21, 6'h3f};
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

      do_reset();

      step(1, 32'h2008FFFF, 1, 0);
      check("addi_fmt", bus.fmt, 1);
      check("addi_rt", bus.rt, 8);
      check("addi_imm", bus.imm_ext, (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF);
      step(1, 32'h3408FFFF, 1, 0);
      check("ori_imm", bus.imm_ext, 64'h0000_FFFF);
      step(1, 32'h3C018000, 1, 0);
      check("lui_imm", bus.imm_ext, (XLEN == 64) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000);
      step(0, 0, 1, 0);

      step(1, 32'h20010001, 0, 0);
      step(1, 32'h20020002, 0, 0);
      check("bp_in_ready", bus.in_ready, 0);
      step(1, 32'h20030003, 0, 0);
      step(0, 0, 1, 0);
      check("bp_second_rt", bus.rt, 2);
      step(0, 0, 1, 0);

      step(1, 32'h0C100000, 1, 0);
      check("jal_fmt", bus.fmt, 2);
      check("jal_addr", bus.address, 26'h0100000);
      step(1, 32'h0109502A, 1, 0);
`ifdef ID_EXT_OPS_EN
      check("slt_fmt", bus.fmt, 0);
      check("slt_rd", bus.rd, 10);
`else
      check("slt_fmt", bus.fmt, 3);
      check("slt_illegal", bus.illegal, 1);
`endif
      step(0, 0, 1, 0);

      step(1, 32'h20040004, 0, 0);
      step(1, 32'h20050005, 0, 0);
      step(1, 32'h20060006, 0, 1);
      check("flush_out_valid", bus.out_valid, 0);
      check("flush_in_ready", bus.in_ready, 1);
      step(0, 0, 1, 0);

      step(1, 32'h20070007, 0, 0);
      step(1, 32'h20080008, 0, 0);
      do_reset();

      for (int i = 0; i < 600; i++)
         step(($urandom % 4) != 0, rand_instr(), ($urandom % 3) != 0, ($urandom % 25) == 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
